// File: rtl/commit_trace_fifo.sv
// Commit-event recorder: timestamps retiring events (halt/reg write/mem write) into a small FIFO
// drained over valid/ready, and keeps the cycle/instruction counters, halt status and a watchdog.
module commit_trace_fifo #(
  parameter int DEPTH      = 8,
  parameter int MAX_CYCLES = 100000,
  parameter int CW         = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   pc,
  input  logic          reg_write,
  input  logic [3:0]    write_reg,
  input  logic [15:0]   write_data,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [15:0]   mem_addr,
  input  logic [15:0]   mem_wdata,
  input  logic [15:0]   mem_rdata,
  input  logic          hlt,
  output logic          rec_valid,
  input  logic          rec_ready,
  output logic [3:0]    rec_kind,
  output logic [15:0]   rec_pc,
  output logic [3:0]    rec_reg,
  output logic [15:0]   rec_rdata,
  output logic [15:0]   rec_maddr,
  output logic [15:0]   rec_mdata,
  output logic [CW-1:0] rec_cycle,
  output logic [CW-1:0] cycle_count,
  output logic [CW-1:0] inst_count,
  output logic [CW-1:0] drop_count,
  output logic          overflow,
  output logic          halted,
  output logic          drained,
  output logic          timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = 4 + 16 + 4 + 16 + 16 + 16 + CW;

  typedef enum logic [1:0] {RUN, HALTED, DONE, TIMEOUT} state_t;

  state_t        state, state_nxt;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [RW-1:0] store [DEPTH];
  logic [RW-1:0] new_rec;
  logic          empty, full, ev, pop, push, drop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign ev    = (state == RUN) && (hlt || reg_write || mem_write);
  assign pop   = !empty && rec_ready;
  // A full FIFO still takes the event when the head leaves in the same cycle.
  assign push  = ev && (!full || pop);
  assign drop  = ev && !push;

  assign new_rec = {hlt, mem_write, mem_read, reg_write, pc, write_reg, write_data,
                    mem_addr, (mem_write ? mem_wdata : mem_rdata), cycle_count};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (ev && hlt)                               state_nxt = HALTED;
        else if (cycle_count == CW'(MAX_CYCLES - 1)) state_nxt = TIMEOUT;
      end
      HALTED:  if (empty) state_nxt = DONE;
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is reset so an idle or freshly reset FIFO reads as zeros, never X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) store[i] <= '0;
    end else if (push) begin
      store[wr_ptr[AW-1:0]] <= new_rec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_count <= '0;
      inst_count  <= '0;
      drop_count  <= '0;
      overflow    <= 1'b0;
    end else begin
      if (state == RUN && cycle_count != '1) cycle_count <= cycle_count + CW'(1);
      if (ev && inst_count != '1)            inst_count  <= inst_count + CW'(1);
      if (drop && drop_count != '1)          drop_count  <= drop_count + CW'(1);
      if (drop)                              overflow    <= 1'b1;
    end
  end

  assign rec_valid = !empty;
  assign {rec_kind, rec_pc, rec_reg, rec_rdata, rec_maddr, rec_mdata, rec_cycle} =
         store[rd_ptr[AW-1:0]];

  assign halted  = (state == HALTED) || (state == DONE);
  assign drained = (state == DONE);
  assign timeout = (state == TIMEOUT);

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Directed bench for commit_trace_fifo: a reference model predicts each record into a queue
// and every pop compares the DUT head against the queue front, alongside status checks.
module tb_commit_trace_fifo;

  localparam int DEPTH = 8;
  localparam int MAXC  = 20;
  localparam int CW    = 32;

  logic          clk, rst;
  logic [15:0]   pc, write_data, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]    write_reg;
  logic          reg_write, mem_read, mem_write, hlt, rec_ready;
  logic          rec_valid, overflow, halted, drained, timeout;
  logic [3:0]    rec_kind, rec_reg;
  logic [15:0]   rec_pc, rec_rdata, rec_maddr, rec_mdata;
  logic [CW-1:0] rec_cycle, cycle_count, inst_count, drop_count;

  typedef struct {
    logic [3:0]    kind;
    logic [15:0]   pc;
    logic [3:0]    rg;
    logic [15:0]   rd;
    logic [15:0]   ma;
    logic [15:0]   md;
    logic [CW-1:0] cyc;
  } rec_t;

  rec_t          sb[$];
  int            mst;
  logic [CW-1:0] mcyc, minst, mdrop;
  logic          movf;
  int            errors = 0;
  int            checks = 0;

  commit_trace_fifo #(.DEPTH(DEPTH), .MAX_CYCLES(MAXC), .CW(CW)) dut (
    .clk(clk), .rst(rst), .pc(pc), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .hlt(hlt),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_kind(rec_kind), .rec_pc(rec_pc),
    .rec_reg(rec_reg), .rec_rdata(rec_rdata), .rec_maddr(rec_maddr), .rec_mdata(rec_mdata),
    .rec_cycle(rec_cycle), .cycle_count(cycle_count), .inst_count(inst_count),
    .drop_count(drop_count), .overflow(overflow), .halted(halted), .drained(drained),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tg);
    chk({tg, "_valid"},   rec_valid,   sb.size() != 0);
    chk({tg, "_cycles"},  cycle_count, mcyc);
    chk({tg, "_insts"},   inst_count,  minst);
    chk({tg, "_drops"},   drop_count,  mdrop);
    chk({tg, "_ovf"},     overflow,    movf);
    chk({tg, "_halted"},  halted,      mst == 1 || mst == 2);
    chk({tg, "_drained"}, drained,     mst == 2);
    chk({tg, "_timeout"}, timeout,     mst == 3);
  endtask

  task automatic idle();
    hlt = 0; reg_write = 0; mem_write = 0; mem_read = 0;
    pc = '0; write_reg = '0; write_data = '0; mem_addr = '0; mem_wdata = '0; mem_rdata = '0;
  endtask

  task automatic regw(input logic [15:0] p, input logic [3:0] r, input logic [15:0] d);
    idle();
    pc = p; reg_write = 1; write_reg = r; write_data = d;
  endtask

  // One clock: predict from the current inputs, check any popped head, then update the model.
  task automatic tick();
    logic ev, pp, acc;
    rec_t r;
    int   nst;
    ev = (mst == 0) && (hlt || reg_write || mem_write);
    pp = (sb.size() != 0) && rec_ready;
    if (pp) begin
      r = sb[0];
      chk("head_kind",  rec_kind,  r.kind);
      chk("head_pc",    rec_pc,    r.pc);
      chk("head_reg",   rec_reg,   r.rg);
      chk("head_rdata", rec_rdata, r.rd);
      chk("head_maddr", rec_maddr, r.ma);
      chk("head_mdata", rec_mdata, r.md);
      chk("head_cycle", rec_cycle, r.cyc);
    end
    acc    = ev && (sb.size() < DEPTH || pp);
    r.kind = {hlt, mem_write, mem_read, reg_write};
    r.pc   = pc;
    r.rg   = write_reg;
    r.rd   = write_data;
    r.ma   = mem_addr;
    r.md   = mem_write ? mem_wdata : mem_rdata;
    r.cyc  = mcyc;
    nst = mst;
    if (mst == 0) begin
      if (ev && hlt) nst = 1;
      else if (mcyc == MAXC - 1) nst = 3;
    end else if (mst == 1 && sb.size() == 0) begin
      nst = 2;
    end
    @(posedge clk); #1;
    if (mst == 0) mcyc++;
    if (ev) minst++;
    if (ev && !acc) begin mdrop++; movf = 1'b1; end
    if (pp) void'(sb.pop_front());
    if (acc) sb.push_back(r);
    mst = nst;
    chk_status("tick");
  endtask

  task automatic do_reset();
    rst = 1;
    pc = 'x; write_reg = 'x; write_data = 'x; mem_addr = 'x; mem_wdata = 'x; mem_rdata = 'x;
    reg_write = 'x; mem_read = 'x; mem_write = 'x; hlt = 'x; rec_ready = 'x;
    #12;
    chk("rst_valid",  rec_valid, 0);
    chk("rst_fields", {rec_kind, rec_pc, rec_reg, rec_rdata, rec_maddr}, 0);
    chk("rst_mdata",  rec_mdata, 0);
    chk("rst_rcycle", rec_cycle, 0);
    chk("rst_counts", {cycle_count, inst_count}, 0);
    chk("rst_drops",  drop_count, 0);
    chk("rst_flags",  {overflow, halted, drained, timeout}, 0);
    idle();
    rec_ready = 0;
    @(posedge clk); #1;
    rst = 0;
    sb.delete();
    mst = 0; mcyc = '0; minst = '0; mdrop = '0; movf = 1'b0;
  endtask

  initial begin
    rst = 1; rec_ready = 0; idle();
    do_reset();

    // single register write after four idle cycles
    repeat (4) tick();
    regw(16'h0002, 4'd3, 16'h1234); tick();
    idle();
    chk("t1_kind",  rec_kind,  4'b0001);
    chk("t1_reg",   rec_reg,   4'd3);
    chk("t1_rdata", rec_rdata, 16'h1234);
    chk("t1_pc",    rec_pc,    16'h0002);
    chk("t1_cycle", rec_cycle, 4);
    chk("t1_insts", inst_count, 1);

    // memory write with consumer ready
    rec_ready = 1; tick();
    idle(); mem_write = 1; mem_addr = 16'h0010; mem_wdata = 16'hBEEF; mem_rdata = 16'h5555;
    tick();
    idle();
    chk("t2_kind",  rec_kind,  4'b0100);
    chk("t2_maddr", rec_maddr, 16'h0010);
    chk("t2_mdata", rec_mdata, 16'hBEEF);
    tick();
    chk("t2_empty", rec_valid, 0);

    // overflow: ten events into an eight-deep FIFO, then drain in order
    do_reset();
    for (int i = 0; i < 10; i++) begin
      regw(16'(16'h0100 + i), 4'(i), 16'(16'hA000 + i)); tick();
    end
    idle();
    chk("t3_drops", drop_count, 2);
    chk("t3_ovf",   overflow,   1);
    chk("t3_insts", inst_count, 10);
    rec_ready = 1;
    repeat (8) tick();
    chk("t3_empty", rec_valid, 0);

    // simultaneous push and pop while full
    do_reset();
    for (int i = 0; i < 8; i++) begin
      regw(16'(16'h0100 + i), 4'(i), 16'(16'hB000 + i)); tick();
    end
    regw(16'h0200, 4'd9, 16'hC0DE); rec_ready = 1; tick();
    idle(); rec_ready = 0;
    chk("t4_drops",   drop_count, 0);
    chk("t4_ovf",     overflow,   0);
    chk("t4_head_pc", rec_pc,     16'h0101);
    rec_ready = 1;
    repeat (8) tick();
    chk("t4_empty", rec_valid, 0);

    // halt with three records queued
    do_reset();
    for (int i = 0; i < 3; i++) begin
      regw(16'(16'h0020 + i), 4'(i + 1), 16'(16'hD000 + i)); tick();
    end
    idle(); hlt = 1; reg_write = 1; write_reg = 4'd7; write_data = 16'h7777; pc = 16'h0030;
    tick();
    idle();
    chk("t5_halted", halted, 1);
    chk("t5_cycles", cycle_count, 4);
    regw(16'h0040, 4'd2, 16'hEEEE); tick(); tick();
    idle();
    chk("t5_frozen", cycle_count, 4);
    chk("t5_insts",  inst_count,  4);
    rec_ready = 1;
    repeat (3) tick();
    chk("t5_last_kind", rec_kind, 4'b1001);
    tick();
    chk("t5_not_yet_drained", drained, 0);
    tick();
    chk("t5_drained", drained, 1);

    // watchdog
    do_reset();
    repeat (19) tick();
    chk("t6_no_timeout", timeout, 0);
    tick();
    chk("t6_timeout", timeout, 1);
    chk("t6_cycles",  cycle_count, MAXC);
    regw(16'h0050, 4'd1, 16'h1111); tick();
    idle();
    chk("t6_no_capture", rec_valid, 0);
    chk("t6_insts",      inst_count, 0);
    rst = 1;
    #2;
    chk("t6_async_timeout", timeout, 0);
    chk("t6_async_cycles",  cycle_count, 0);
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/commit_trace_fifo.md
Name: commit_trace_fifo

Overview:
- Hardware commit-event recorder inside the cpu, fed by the writeback/memory-stage commit signals.
- Each cycle it tests for a retiring event (Halt, RegWrite or MemWrite). A retiring event is timestamped and pushed into a small FIFO.
- A consumer drains the FIFO with a valid/ready handshake. Consumers are an on-chip trace port or a bench-side reader that rebuilds the REG/LOAD/STORE trace.
- The block also keeps the cycle and instruction counters, halt/drain status and a runaway-cycle watchdog.

Parameters:
- DEPTH, 8, FIFO entries; must be a power of 2, minimum 2.
- MAX_CYCLES, 100000, cycle limit that trips the watchdog.
- CW, 32, width of the cycle and instruction counters.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- pc  in  16  PC of the retiring instruction
- reg_write  in  1  register file written this cycle
- write_reg  in  4  destination register
- write_data  in  16  register write data
- mem_read  in  1  data memory read this cycle
- mem_write  in  1  data memory write this cycle
- mem_addr  in  16  data memory address
- mem_wdata  in  16  data written to memory
- mem_rdata  in  16  data read from memory
- hlt  in  1  halt retiring this cycle
- rec_valid  out  1  head record available
- rec_ready  in  1  consumer accepts head record
- rec_kind  out  4  {hlt, mem_write, mem_read, reg_write} of head record
- rec_pc  out  16  head record PC
- rec_reg  out  4  head record write_reg
- rec_rdata  out  16  head record write_data
- rec_maddr  out  16  head record mem_addr
- rec_mdata  out  16  head record mem_wdata if mem_write, else mem_rdata
- rec_cycle  out  CW  cycle_count value at capture
- cycle_count  out  CW  cycles elapsed in RUN
- inst_count  out  CW  retire events seen
- drop_count  out  CW  events lost to a full FIFO
- overflow  out  1  sticky; set when any event is dropped
- halted  out  1  halt has retired
- drained  out  1  halted and FIFO empty
- timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (async, rst=1):
  - State goes to RUN. FIFO pointers and count are cleared.
  - All counters and flags are 0: rec_valid, overflow, halted, drained, timeout.
  - Record output fields read 0.
- States: RUN, HALTED, DONE, TIMEOUT.
  - RUN -> HALTED on a capture with hlt=1.
  - HALTED -> DONE when the FIFO is empty.
  - RUN -> TIMEOUT when cycle_count == MAX_CYCLES-1 at the clock edge.
  - DONE and TIMEOUT are terminal until reset.
  - HALTED and TIMEOUT both still allow draining.
- Capture condition: `ev = (state==RUN) & (hlt | reg_write | mem_write)`.
  - A mem_read with no reg_write is not an event.
  - mem_read is recorded only as a kind bit.
- Counters:
  - cycle_count increments every cycle in RUN only and freezes otherwise.
  - inst_count increments on every ev, including dropped events.
  - All counters saturate at all-ones.
- Push rule:
  - Accepted when `ev & (!full | pop)`. Push and pop in the same cycle while full is legal; the count is unchanged.
  - Otherwise the event is dropped: drop_count increments and overflow is set.
  - A dropped halt still moves the block to HALTED.
- rec_cycle stores the pre-increment cycle_count.
- Pop: `pop = rec_valid & rec_ready`. The head advances at the clock edge.
- Read side:
  - rec_valid = !empty. Record fields are driven from storage at the read pointer.
  - Latency is 1: an event captured at edge N is visible after edge N (same cycle if the FIFO was empty).
  - Fields hold stable while rec_valid=1 and rec_ready=0.
- Pointers are log2(DEPTH)+1 bits with natural wrap. full/empty are derived from the MSB compare.
- Status flags:
  - halted = state in {HALTED, DONE}.
  - drained = (state==DONE).
  - timeout = (state==TIMEOUT).
- hlt together with reg_write/mem_write in one cycle produces a single record with multiple kind bits set.
- Input X while rst=1 must not propagate to any output.

Test Plan:
1. Reset, then RegWrite r3=0x1234 at PC 0x0002 in cycle 5 -> one record: kind=0001, reg=3, rdata=0x1234, pc=0x0002, rec_cycle=4; inst_count=1.
2. mem_write to addr 0x0010 with data 0xBEEF, rec_ready=1 -> kind=0100, maddr=0x0010, mdata=0xBEEF; the FIFO empties the next cycle.
3. rec_ready=0, 10 consecutive reg_write events, DEPTH=8 -> 8 stored, drop_count=2, overflow=1, inst_count=10. Then rec_ready=1 -> 8 records pop in order.
4. FIFO full while push and pop occur in the same cycle -> no drop, count stays 8, overflow stays 0.
5. hlt with 3 records queued -> halted=1, cycle_count freezes, later events ignored. drained=1 one cycle after the 4th pop; the last record has kind bit3=1.
6. MAX_CYCLES=20 with no halt -> timeout=1 after cycle_count reaches 19, capture stops. Asserting rst mid-run clears all flags immediately.
